// File: rtl/mem_byte_responder_if.sv
// Core-side memory-stage bus between the cpu core (master) and mem_byte_responder (slave).
interface mem_byte_responder_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN-1:0]        mem_write;
  logic [1:0]            mem_stage_state;
  logic [1:0]            mem_size;
  logic [LEN-1:0]        mem_read;
  logic                  mem_done;
  logic                  mem_err;

  modport master (
    output addr, mem_write, mem_stage_state, mem_size,
    input  mem_read, mem_done, mem_err
  );

  modport slave (
    input  addr, mem_write, mem_stage_state, mem_size,
    output mem_read, mem_done, mem_err
  );
endinterface

// File: rtl/mem_byte_responder.sv
// Serializes byte/half/word core requests into little-endian single-byte RAM accesses.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word requests complete at once with mem_err.
module mem_byte_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_byte_responder_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BYTE_SIZE-1:0]  ram_wdata,
  output logic                  ram_we,
  input  logic [BYTE_SIZE-1:0]  ram_rdata
);
  localparam int NB = LEN / BYTE_SIZE;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         nbytes;
  logic [CW-1:0]         req_nbytes;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN-1:0]        wbuf;
  logic                  req_rd, req_wr, accept, misaligned;

  assign req_rd = (bus.mem_stage_state == 2'b01);
  assign req_wr = (bus.mem_stage_state == 2'b10);
  assign accept = (state == IDLE) && (req_rd || req_wr);

  always_comb begin
    unique case (bus.mem_size)
      2'b00:   req_nbytes = CW'(1);
      2'b01:   req_nbytes = CW'(2);
      default: req_nbytes = CW'(4);
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = ((bus.mem_size == 2'b01) && bus.addr[0]) ||
                      (bus.mem_size[1] && (bus.addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= misaligned;
  end

  assign bus.mem_err = (state == DONE) && err_q;
`else
  assign misaligned  = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req_rd || req_wr) state_nx = misaligned ? DONE : (req_rd ? READ : WRITE);
      READ:  if (cnt == nbytes) state_nx = DONE;
      WRITE: if (cnt == nbytes - CW'(1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end

  // RAM side decodes only from registered state; rst gates the write strobe so an
  // abort never lands one more byte on the reset edge.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (state == WRITE || (state == READ && cnt != nbytes))
      ram_addr = base + ADDR_WIDTH'(cnt);
    if (state == WRITE) begin
      ram_we = !rst;
      for (int i = 0; i < NB; i++)
        if (cnt == CW'(i)) ram_wdata = wbuf[i*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  assign bus.mem_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      nbytes       <= '0;
      base         <= '0;
      wbuf         <= '0;
      bus.mem_read <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          base         <= bus.addr;
          wbuf         <= bus.mem_write;
          nbytes       <= req_nbytes;
          cnt          <= '0;
          bus.mem_read <= '0;
        end
        READ: begin
          // Byte k-1 returns from the RAM while cnt == k.
          for (int i = 0; i < NB; i++)
            if (cnt == CW'(i + 1)) bus.mem_read[i*BYTE_SIZE +: BYTE_SIZE] <= ram_rdata;
          if (cnt != nbytes) cnt <= cnt + CW'(1);
        end
        WRITE: cnt <= cnt + CW'(1);
        DONE:  cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_byte_responder.sv
// Randomized self-checking bench for mem_byte_responder with a byte RAM and a shadow-memory model.
module tb_mem_byte_responder;
  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;

  mem_byte_responder_if #(.ADDR_WIDTH(AW), .LEN(32)) bus ();

  mem_byte_responder #(.ADDR_WIDTH(AW), .LEN(32), .BYTE_SIZE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  logic [7:0]  ram     [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] last_rd;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [AW-1:0] a);
    logic m;
    m = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    m = (size == 2'b01 && a[0]) || (size[1] && a[1:0] != 2'b00);
`endif
    return m;
  endfunction

  // One transaction presented at the current negedge; checks every beat, latency and result.
  task automatic txn(input logic wr, input logic [1:0] size, input logic [AW-1:0] a,
                     input logic [31:0] wd);
    int            n, lat;
    logic          mis, seen;
    logic [31:0]   exp_rd;
    logic [AW-1:0] ak;
    n      = size_bytes(size);
    mis    = is_misaligned(size, a);
    lat    = mis ? 1 : (wr ? n + 1 : n + 2);
    exp_rd = '0;
    if (!wr && !mis)
      for (int k = 0; k < n; k++) begin
        ak = a + AW'(k);
        exp_rd[8*k +: 8] = ref_mem[ak];
      end
    if (wr && !mis)
      for (int k = 0; k < n; k++) begin
        ak = a + AW'(k);
        ref_mem[ak] = wd[8*k +: 8];
      end
    last_rd = exp_rd;

    bus.addr            = a;
    bus.mem_write       = wd;
    bus.mem_size        = size;
    bus.mem_stage_state = wr ? 2'b10 : 2'b01;
    seen = 1'b0;
    for (int off = 1; off <= lat + 3 && !seen; off++) begin
      @(negedge clk);
      if (off == 1) begin
        bus.mem_stage_state = 2'b00;
        bus.addr            = AW'($urandom);
        bus.mem_write       = $urandom;
        bus.mem_size        = 2'($urandom);
      end
      check("ram_we", ram_we, (wr && !mis && off <= n) ? 1'b1 : 1'b0);
      if (!mis && off <= n) begin
        ak = a + AW'(off - 1);
        check(wr ? "wr_addr" : "rd_addr", ram_addr, ak);
        if (wr) check("wr_data", ram_wdata, wd[8*(off-1) +: 8]);
      end
      if (bus.mem_done) begin
        seen = 1'b1;
        check("done_latency", off, lat);
        check("mem_err", bus.mem_err, mis);
        check("mem_read", bus.mem_read, exp_rd);
      end
    end
    check("done_seen", seen, 1'b1);
    @(negedge clk);
    check("done_one_cycle", bus.mem_done, 1'b0);
    check("read_hold", bus.mem_read, exp_rd);
  endtask

  task automatic reset_abort(input logic [AW-1:0] a, input logic [31:0] wd);
    logic [AW-1:0] ak;
    int            dones;
    bus.addr            = a;
    bus.mem_write       = wd;
    bus.mem_size        = 2'b10;
    bus.mem_stage_state = 2'b10;
    @(negedge clk);
    bus.mem_stage_state = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_we_gated", ram_we, 1'b0);
    dones = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_we", ram_we, 1'b0);
      check("abort_addr", ram_addr, '0);
      if (bus.mem_done) dones++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_done || ram_we) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_read_clr", bus.mem_read, '0);
    ref_mem[a] = wd[7:0];
    ak = a + AW'(1);
    ref_mem[ak] = wd[15:8];
    for (int k = 0; k < 4; k++) begin
      ak = a + AW'(k);
      check("abort_ram", ram[ak], ref_mem[ak]);
    end
    last_rd = '0;
  endtask

  // Read held across mem_done: each re-acceptance happens in the IDLE cycle after DONE.
  task automatic back_to_back(input logic [AW-1:0] a);
    int          pulses, stray;
    logic [31:0] exp_rd;
    exp_rd = {16'h0, ref_mem[a + AW'(1)], ref_mem[a]};
    bus.addr            = a;
    bus.mem_size        = 2'b01;
    bus.mem_write       = $urandom;
    bus.mem_stage_state = 2'b01;
    pulses = 0;
    stray  = 0;
    for (int off = 1; off <= 25; off++) begin
      @(negedge clk);
      if (ram_we) stray++;
      if (bus.mem_done) begin
        pulses++;
        check("b2b_done_at", off, 4 + 5 * (pulses - 1));
        check("b2b_data", bus.mem_read, exp_rd);
        if (pulses == 3) bus.mem_stage_state = 2'b00;
      end
    end
    check("b2b_pulses", pulses, 3);
    check("b2b_no_we", stray, 0);
    last_rd = exp_rd;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [1:0]    sz;
    int            bad, seen11;
    checks   = 0;
    failures = 0;
    last_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    rst                 = 1'b1;
    bus.addr            = '0;
    bus.mem_write       = '0;
    bus.mem_size        = '0;
    bus.mem_stage_state = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_done", bus.mem_done, 1'b0);
      check("idle_we", ram_we, 1'b0);
      check("idle_read", bus.mem_read, '0);
      check("idle_addr", ram_addr, '0);
    end

    bus.mem_stage_state = 2'b11;
    seen11 = 0;
    for (int i = 0; i < 8; i++) begin
      bus.addr = AW'($urandom);
      @(negedge clk);
      if (bus.mem_done || ram_we) seen11++;
    end
    check("reserved_ignored", seen11, 0);
    bus.mem_stage_state = 2'b00;
    @(negedge clk);

    ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
    ref_mem[17'h100] = 8'h11; ref_mem[17'h101] = 8'h22;
    ref_mem[17'h102] = 8'h33; ref_mem[17'h103] = 8'h44;
    txn(1'b0, 2'b10, 17'h100, 32'h0);
    check("word_read_val", bus.mem_read, 32'h4433_2211);
    txn(1'b1, 2'b10, 17'h200, 32'hDEAD_BEEF);
    txn(1'b0, 2'b00, 17'h202, 32'h0);
    check("byte_read_val", bus.mem_read, 32'h0000_00AD);
    txn(1'b1, 2'b01, 17'h1FFFF, 32'h0000_A5A5);
    check("wrap_hi", ram[17'h1FFFF], ref_mem[17'h1FFFF]);
    check("wrap_lo", ram[17'h00000], ref_mem[17'h00000]);
    reset_abort(17'h400, 32'hCAFE_F00D);
    back_to_back(17'h500);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? AW'(17'h1FFFC + 17'($urandom_range(0, 3)))
                                       : AW'($urandom);
      txn(1'($urandom_range(0, 1)), sz, a, $urandom);
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== ref_mem[i]) bad++;
    check("final_ram_image", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
